// File: rtl/sonic_v1_15_eth_10g_pause_req_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sonic_v1_15_eth_10g_pause_req_ctrl_pkg
// Brief    : Shared types and constants for the 10G pause request controller.
// Revision : 1.0
// ============================================================================
package sonic_v1_15_eth_10g_pause_req_ctrl_pkg;

  localparam int QUANTA_W_DEFAULT  = 16;
  localparam int HOLDOFF_W_DEFAULT = 16;

  localparam logic [1:0] PAUSE_CMD_XOFF = 2'b10;
  localparam logic [1:0] PAUSE_CMD_XON  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_XOFF_SEND = 2'd1,
    ST_XOFF_HOLD = 2'd2,
    ST_XON_SEND  = 2'd3
  } pause_state_e;

endpackage
`default_nettype wire

// File: rtl/sonic_v1_15_eth_10g_pause_req_ctrl_holdoff_timer.sv
`default_nettype none
// ============================================================================
// Module   : sonic_v1_15_eth_10g_pause_holdoff_timer
// Brief    : Loadable down-counter; flags the cycle in which it reaches zero.
// Revision : 1.0
// ============================================================================
module sonic_v1_15_eth_10g_pause_holdoff_timer #(
  parameter int HOLDOFF_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [HOLDOFF_W-1:0] load_value,
  input  logic                 dec,
  output logic                 expire
);

  logic [HOLDOFF_W-1:0] r_count;

  // A zero count is parked: it never decrements and never expires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - HOLDOFF_W'(1);
    end
  end

  assign expire = dec && (r_count == HOLDOFF_W'(1));

endmodule
`default_nettype wire

// File: rtl/sonic_v1_15_eth_10g_pause_req_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sonic_v1_15_eth_10g_pause_req_ctrl
// Brief    : Turns XOFF/XON pause commands into pause-frame transmit requests.
// Revision : 1.0
// ============================================================================
module sonic_v1_15_eth_10g_pause_req_ctrl
  import sonic_v1_15_eth_10g_pause_req_ctrl_pkg::*;
#(
  parameter int QUANTA_W  = QUANTA_W_DEFAULT,
  parameter int HOLDOFF_W = HOLDOFF_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 cfg_enable,
  input  logic [QUANTA_W-1:0]  cfg_quanta,
  input  logic [HOLDOFF_W-1:0] cfg_holdoff,
  output logic                 pause_req_valid,
  output logic [QUANTA_W-1:0]  pause_req_quanta,
  input  logic                 pause_req_ready,
  output logic                 xoff_active
);

  pause_state_e r_state;
  logic         r_pend_xon;
  logic         r_pend_xoff;

  logic w_cmd_xoff;
  logic w_cmd_xon;
  logic w_handshake;
  logic w_pend_xon_next;
  logic w_pend_xoff_next;
  logic w_go_xon;
  logic w_timer_load;
  logic w_timer_dec;
  logic w_timer_expire;

  assign in_ready    = 1'b1;
  assign w_cmd_xoff  = in_valid && (in_data == PAUSE_CMD_XOFF);
  assign w_cmd_xon   = in_valid && (in_data == PAUSE_CMD_XON);
  assign w_handshake = pause_req_valid && pause_req_ready;

  // Commands arriving in the handshake cycle itself still count as pending.
  assign w_pend_xon_next  = r_pend_xon || w_cmd_xon;
  assign w_pend_xoff_next = w_cmd_xoff ? 1'b1 : (w_cmd_xon ? 1'b0 : r_pend_xoff);
  assign w_go_xon         = w_pend_xon_next || !cfg_enable;

  assign w_timer_load = (r_state == ST_XOFF_SEND) && w_handshake && !w_go_xon;
  assign w_timer_dec  = (r_state == ST_XOFF_HOLD);

  sonic_v1_15_eth_10g_pause_holdoff_timer #(
    .HOLDOFF_W (HOLDOFF_W)
  ) u_holdoff_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (w_timer_load),
    .load_value (cfg_holdoff),
    .dec        (w_timer_dec),
    .expire     (w_timer_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state          <= ST_IDLE;
      r_pend_xon       <= 1'b0;
      r_pend_xoff      <= 1'b0;
      pause_req_valid  <= 1'b0;
      pause_req_quanta <= '0;
      xoff_active      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_xoff && cfg_enable) begin
            r_state          <= ST_XOFF_SEND;
            pause_req_valid  <= 1'b1;
            pause_req_quanta <= cfg_quanta;
            xoff_active      <= 1'b1;
          end
        end

        ST_XOFF_SEND: begin
          if (w_handshake) begin
            r_pend_xon <= 1'b0;
            if (w_go_xon) begin
              r_state          <= ST_XON_SEND;
              pause_req_valid  <= 1'b1;
              pause_req_quanta <= '0;
              xoff_active      <= 1'b0;
            end else begin
              r_state         <= ST_XOFF_HOLD;
              pause_req_valid <= 1'b0;
            end
          end else begin
            r_pend_xon <= w_pend_xon_next;
          end
        end

        // Release wins over a refresh that expires in the same cycle.
        ST_XOFF_HOLD: begin
          if (w_cmd_xon || !cfg_enable) begin
            r_state          <= ST_XON_SEND;
            pause_req_valid  <= 1'b1;
            pause_req_quanta <= '0;
            xoff_active      <= 1'b0;
          end else if (w_timer_expire) begin
            r_state          <= ST_XOFF_SEND;
            pause_req_valid  <= 1'b1;
            pause_req_quanta <= cfg_quanta;
          end
        end

        ST_XON_SEND: begin
          if (w_handshake) begin
            r_pend_xoff <= 1'b0;
            if (w_pend_xoff_next && cfg_enable) begin
              r_state          <= ST_XOFF_SEND;
              pause_req_valid  <= 1'b1;
              pause_req_quanta <= cfg_quanta;
              xoff_active      <= 1'b1;
            end else begin
              r_state          <= ST_IDLE;
              pause_req_valid  <= 1'b0;
              pause_req_quanta <= '0;
            end
          end else begin
            r_pend_xoff <= w_pend_xoff_next;
          end
        end

        default: begin
          r_state          <= ST_IDLE;
          pause_req_valid  <= 1'b0;
          pause_req_quanta <= '0;
          xoff_active      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
